// File: rtl/fbuf_pkg.sv
// Shared framebuffer constants and the write-arbiter state encoding.
package fbuf_pkg;

   localparam int FBUF_ADDR_W     = 19;
   localparam int FBUF_DATA_W     = 8;
   localparam int FBUF_SCREEN_W   = 640;
   localparam int FBUF_SCREEN_H   = 480;
   localparam int FBUF_NUM_PIXELS = FBUF_SCREEN_W * FBUF_SCREEN_H;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/fbuf_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; returns the first set request
// at or above i_ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   always_comb begin : p_pick
      int            v_j;
      logic [IW-1:0] v_idx;
      // NOTE: every output gets a default before the loop, so no path can
      // leave a value unassigned and infer a latch.
      o_idx   = i_ptr;
      o_found = 1'b0;
      v_j     = 0;
      v_idx   = '0;
      for (int k = 0; k < N; k++) begin
         v_j = int'(i_ptr) + k;
         if (v_j >= N) v_j = v_j - N;
         v_idx = IW'(v_j);
         if (!o_found && i_req[v_idx]) begin
            o_found = 1'b1;
            o_idx   = v_idx;
         end
      end
   end

endmodule

// File: rtl/fbuf_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the framebuffer BRAM write port.
// Optional out-of-range address clipping: define FBUF_WR_ARB_CLIP_EN.
module fbuf_wr_arbiter
   import fbuf_pkg::*;
#(
   parameter int NUM_REQ         = 3,
   parameter int FBUF_ADDR_WIDTH = FBUF_ADDR_W,
   parameter int FBUF_DATA_WIDTH = FBUF_DATA_W,
   parameter int MAX_BURST       = 64
`ifdef FBUF_WR_ARB_CLIP_EN
   ,
   parameter int FBUF_DEPTH      = FBUF_NUM_PIXELS
`endif
) (
   input  logic                                 fbuf_aclk,
   input  logic                                 fbuf_areset,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0]                   req_last,
   input  logic [NUM_REQ*FBUF_ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*FBUF_DATA_WIDTH-1:0]   req_data,
   output logic                                 fbuf_en_wr,
   output logic                                 fbuf_wrea,
   output logic [FBUF_ADDR_WIDTH-1:0]           fbuf_addr,
   output logic [FBUF_DATA_WIDTH-1:0]           fbuf_data,
   output logic [$clog2(NUM_REQ)-1:0]           grant_id,
   output logic                                 busy
`ifdef FBUF_WR_ARB_CLIP_EN
   ,
   output logic                                 clip_err
`endif
);

   localparam int IDW   = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST);

   arb_state_t                 r_state, w_state_nxt;
   logic [IDW-1:0]             r_ptr, w_ptr_nxt;
   logic [IDW-1:0]             r_grant, w_grant_nxt;
   logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
   logic [IDW-1:0]             w_pick_idx;
   logic                       w_pick_found;
   logic                       w_accept;
   logic                       w_write;
   logic                       r_en;
   logic [FBUF_ADDR_WIDTH-1:0] r_addr;
   logic [FBUF_DATA_WIDTH-1:0] r_data;
   logic [FBUF_ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
   logic [FBUF_DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = req_addr[gi*FBUF_ADDR_WIDTH +: FBUF_ADDR_WIDTH];
      assign w_data_arr[gi] = req_data[gi*FBUF_DATA_WIDTH +: FBUF_DATA_WIDTH];
   end

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IDW)
   ) u_rr_pick (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_grant_nxt = r_grant;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      req_ready   = '0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_found) begin
               w_state_nxt = ARB_GRANT;
               w_grant_nxt = w_pick_idx;
               w_cnt_nxt   = '0;
            end
         end
         ARB_GRANT: begin
            req_ready[r_grant] = 1'b1;
            w_accept           = req_valid[r_grant];
            if (w_accept) begin
               w_cnt_nxt = r_cnt + 1'b1;
               // The beat limit ends the grant exactly like req_last does.
               if (req_last[r_grant] || (r_cnt == CNT_W'(MAX_BURST - 1))) begin
                  w_state_nxt = ARB_IDLE;
                  w_ptr_nxt   = (r_grant == IDW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
               end
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

`ifdef FBUF_WR_ARB_CLIP_EN
   logic w_clip;
   logic r_clip_err;

   assign w_clip  = w_accept &&
                    ({1'b0, w_addr_arr[r_grant]} >= (FBUF_ADDR_WIDTH + 1)'(FBUF_DEPTH));
   assign w_write = w_accept && !w_clip;

   always_ff @(posedge fbuf_aclk or posedge fbuf_areset) begin
      if (fbuf_areset) r_clip_err <= 1'b0;
      else if (w_clip) r_clip_err <= 1'b1;
   end

   assign clip_err = r_clip_err;
`else
   assign w_write = w_accept;
`endif

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before this edge, independent of block order.
   always_ff @(posedge fbuf_aclk or posedge fbuf_areset) begin
      if (fbuf_areset) begin
         r_state <= ARB_IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_grant <= w_grant_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Address and data hold on idle slots; only the enable pulses.
   always_ff @(posedge fbuf_aclk or posedge fbuf_areset) begin
      if (fbuf_areset) begin
         r_en   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_en <= w_write;
         if (w_write) begin
            r_addr <= w_addr_arr[r_grant];
            r_data <= w_data_arr[r_grant];
         end
      end
   end

   assign fbuf_en_wr = r_en;
   assign fbuf_wrea  = r_en;
   assign fbuf_addr  = r_addr;
   assign fbuf_data  = r_data;
   assign grant_id   = r_grant;
   assign busy       = (r_state == ARB_GRANT);

endmodule

// File: tb/tb_fbuf_wr_arbiter.sv
// Self-checking bench for fbuf_wr_arbiter (NUM_REQ=3, MAX_BURST=4).
module tb_fbuf_wr_arbiter;

   localparam int NR = 3;
   localparam int AW = 19;
   localparam int DW = 8;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_ready;
   logic [NR-1:0]   req_last = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic            fbuf_en_wr, fbuf_wrea;
   logic [AW-1:0]   fbuf_addr;
   logic [DW-1:0]   fbuf_data;
   logic [1:0]      grant_id;
   logic            busy;
`ifdef FBUF_WR_ARB_CLIP_EN
   logic            clip_err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fbuf_wr_arbiter #(
      .NUM_REQ         (NR),
      .FBUF_ADDR_WIDTH (AW),
      .FBUF_DATA_WIDTH (DW),
      .MAX_BURST       (MB)
   ) dut (
      .fbuf_aclk   (clk),
      .fbuf_areset (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_last    (req_last),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .fbuf_en_wr  (fbuf_en_wr),
      .fbuf_wrea   (fbuf_wrea),
      .fbuf_addr   (fbuf_addr),
      .fbuf_data   (fbuf_data),
      .grant_id    (grant_id),
      .busy        (busy)
`ifdef FBUF_WR_ARB_CLIP_EN
      ,
      .clip_err    (clip_err)
`endif
   );

   typedef struct {
      bit            rst;
      logic [2:0]    v;
      logic [2:0]    l;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [2:0]    rdy;
      logic          bsy;
      logic [1:0]    gid;
      logic          en;
      logic [AW-1:0] fa;
      logic [DW-1:0] fd;
   } vec_t;

   vec_t vecs[$];

   logic [AW-1:0] q_addr[$];
   logic [DW-1:0] q_data[$];
   int exp_a[7] = '{'h100, 'h101, 'h102, 'h103, 'h200, 'h104, 'h105};
   int exp_d[7] = '{'h60, 'h61, 'h62, 'h63, 'h77, 'h64, 'h65};

   function automatic vec_t mk(input bit r, input logic [2:0] v, input logic [2:0] l,
                               input int a, input int d, input logic [2:0] rdy,
                               input logic bsy, input logic [1:0] gid, input logic en,
                               input int fa, input int fd);
      vec_t t;
      t.rst = r;  t.v = v;  t.l = l;  t.a = AW'(a);  t.d = DW'(d);
      t.rdy = rdy; t.bsy = bsy; t.gid = gid; t.en = en;
      t.fa = AW'(fa); t.fd = DW'(fd);
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_all(input logic [2:0] v, input logic [2:0] l,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = v;
      req_last  = l;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = a;
         req_data[i*DW +: DW] = d;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_all(3'b000, 3'b000, '0, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single requester burst, then pointer probe and steady round-robin.
      vecs.push_back(mk(1, 3'b010, 3'b000, 'h10, 'hA0, 3'b000, 0, 0, 0, 'h00, 'h00));
      vecs.push_back(mk(0, 3'b010, 3'b000, 'h10, 'hA0, 3'b010, 1, 1, 0, 'h00, 'h00));
      vecs.push_back(mk(0, 3'b010, 3'b000, 'h11, 'hA1, 3'b010, 1, 1, 1, 'h10, 'hA0));
      vecs.push_back(mk(0, 3'b010, 3'b000, 'h12, 'hA2, 3'b010, 1, 1, 1, 'h11, 'hA1));
      vecs.push_back(mk(0, 3'b010, 3'b010, 'h13, 'hA3, 3'b010, 1, 1, 1, 'h12, 'hA2));
      vecs.push_back(mk(0, 3'b000, 3'b000, 'h13, 'hA3, 3'b000, 0, 0, 1, 'h13, 'hA3));
      vecs.push_back(mk(0, 3'b111, 3'b111, 'h20, 'hB0, 3'b000, 0, 0, 0, 'h13, 'hA3));
      vecs.push_back(mk(0, 3'b111, 3'b111, 'h20, 'hB0, 3'b100, 1, 2, 0, 'h13, 'hA3));
      vecs.push_back(mk(0, 3'b111, 3'b111, 'h21, 'hB1, 3'b000, 0, 0, 1, 'h20, 'hB0));
      vecs.push_back(mk(0, 3'b111, 3'b111, 'h22, 'hB2, 3'b001, 1, 0, 0, 'h20, 'hB0));
      vecs.push_back(mk(0, 3'b111, 3'b111, 'h23, 'hB3, 3'b000, 0, 0, 1, 'h22, 'hB2));
      vecs.push_back(mk(0, 3'b111, 3'b111, 'h24, 'hB4, 3'b010, 1, 1, 0, 'h22, 'hB2));
      vecs.push_back(mk(0, 3'b111, 3'b111, 'h25, 'hB5, 3'b000, 0, 0, 1, 'h24, 'hB4));
      vecs.push_back(mk(0, 3'b111, 3'b111, 'h26, 'hB6, 3'b100, 1, 2, 0, 'h24, 'hB4));
      vecs.push_back(mk(0, 3'b000, 3'b000, 'h26, 'hB6, 3'b000, 0, 0, 1, 'h26, 'hB6));
      vecs.push_back(mk(0, 3'b000, 3'b000, 'h26, 'hB6, 3'b000, 0, 0, 0, 'h26, 'hB6));
      // Stall: valid drops for three cycles mid-burst, grant is held.
      vecs.push_back(mk(1, 3'b010, 3'b000, 'h300, 'h30, 3'b000, 0, 0, 0, 'h000, 'h00));
      vecs.push_back(mk(0, 3'b010, 3'b000, 'h300, 'h30, 3'b010, 1, 1, 0, 'h000, 'h00));
      vecs.push_back(mk(0, 3'b010, 3'b000, 'h301, 'h31, 3'b010, 1, 1, 1, 'h300, 'h30));
      vecs.push_back(mk(0, 3'b000, 3'b000, 'h302, 'h32, 3'b010, 1, 1, 1, 'h301, 'h31));
      vecs.push_back(mk(0, 3'b000, 3'b000, 'h302, 'h32, 3'b010, 1, 1, 0, 'h301, 'h31));
      vecs.push_back(mk(0, 3'b000, 3'b000, 'h302, 'h32, 3'b010, 1, 1, 0, 'h301, 'h31));
      vecs.push_back(mk(0, 3'b010, 3'b000, 'h302, 'h32, 3'b010, 1, 1, 0, 'h301, 'h31));
      vecs.push_back(mk(0, 3'b010, 3'b010, 'h303, 'h33, 3'b010, 1, 1, 1, 'h302, 'h32));
      vecs.push_back(mk(0, 3'b000, 3'b000, 'h303, 'h33, 3'b000, 0, 0, 1, 'h303, 'h33));

      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            do_reset();
            check($sformatf("v%0d_reset_busy", i), busy, 0);
         end
         drive_all(vecs[i].v, vecs[i].l, vecs[i].a, vecs[i].d);
         @(negedge clk);
         check($sformatf("v%0d_ready", i), req_ready, vecs[i].rdy);
         check($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
         if (vecs[i].bsy) check($sformatf("v%0d_grant_id", i), grant_id, vecs[i].gid);
         check($sformatf("v%0d_en_wr", i), fbuf_en_wr, vecs[i].en);
         check($sformatf("v%0d_wrea", i), fbuf_wrea, vecs[i].en);
         check($sformatf("v%0d_addr", i), fbuf_addr, vecs[i].fa);
         check($sformatf("v%0d_data", i), fbuf_data, vecs[i].fd);
         @(posedge clk);
         #1;
      end

      // Reset mid-burst: pointer is 2 here, so req1 wins; abort after beat 2.
      begin
         int   beat = 0;
         int   wr   = 0;
         logic acc;
         for (int cyc = 0; cyc < 30; cyc++) begin
            drive_all(3'b010, (beat == 4) ? 3'b010 : 3'b000,
                      AW'(32'h500 + beat), DW'(32'h50 + beat));
            @(negedge clk);
            if (fbuf_en_wr) wr++;
            if (wr == 2) break;
            acc = req_valid[1] & req_ready[1];
            @(posedge clk);
            #1;
            if (acc) beat++;
         end
         check("rst_reached_beat2", wr, 2);
         check("rst_beat2_addr", fbuf_addr, 'h501);
         #2 rst = 1'b1;
         #1;
         check("rst_async_en_wr", fbuf_en_wr, 0);
         check("rst_async_wrea", fbuf_wrea, 0);
         check("rst_async_addr", fbuf_addr, 0);
         check("rst_async_data", fbuf_data, 0);
         check("rst_async_busy", busy, 0);
         check("rst_async_grant", grant_id, 0);
         check("rst_async_ready", req_ready, 0);
         @(posedge clk);
         #1;
         check("rst_hold_en_wr", fbuf_en_wr, 0);
         @(negedge clk);
         rst = 1'b0;
         drive_all(3'b101, 3'b101, AW'(32'h600), DW'(32'h66));
         check("rst_release_idle", busy, 0);
         @(posedge clk);
         @(negedge clk);
         check("rst_ptr0_busy", busy, 1);
         check("rst_ptr0_grant", grant_id, 0);
         check("rst_ptr0_ready", req_ready, 3'b001);
      end

      // Round-robin from reset with all requesters sending one-beat bursts.
      do_reset();
      drive_all(3'b111, 3'b111, AW'(32'h700), DW'(32'h70));
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check($sformatf("rr%0d_busy", k), busy, 32'(k % 2));
         if (k % 2 == 1) check($sformatf("rr%0d_grant", k), grant_id, 32'((k / 2) % 3));
         check($sformatf("rr%0d_en_wr", k), fbuf_en_wr, 32'(k >= 2 && k % 2 == 0));
         @(posedge clk);
         #1;
      end

      // MAX_BURST cut: req0 six beats, req2 one beat waiting.
      do_reset();
      begin
         int   b = 0;
         bit   sent2 = 1'b0;
         int   bad_ready = 0;
         int   saw2 = 0;
         logic acc0, acc2;
         for (int cyc = 0; cyc < 40; cyc++) begin
            req_valid = {~sent2, 1'b0, (b < 6)};
            req_last  = {1'b1, 1'b0, (b == 5)};
            req_addr  = '0;
            req_data  = '0;
            req_addr[0 +: AW]    = AW'(32'h100 + b);
            req_addr[2*AW +: AW] = AW'(32'h200);
            req_data[0 +: DW]    = DW'(32'h60 + b);
            req_data[2*DW +: DW] = DW'(32'h77);
            @(negedge clk);
            if (fbuf_en_wr) begin
               q_addr.push_back(fbuf_addr);
               q_data.push_back(fbuf_data);
            end
            if (busy && grant_id == 2'd2) begin
               saw2++;
               if (req_ready[0]) bad_ready++;
            end
            if (q_addr.size() == 7) break;
            acc0 = req_valid[0] & req_ready[0];
            acc2 = req_valid[2] & req_ready[2];
            @(posedge clk);
            #1;
            if (acc0) b++;
            if (acc2) sent2 = 1'b1;
         end
         check("mb_write_count", q_addr.size(), 7);
         for (int i = 0; i < 7; i++) begin
            if (i < q_addr.size()) begin
               check($sformatf("mb_addr%0d", i), q_addr[i], exp_a[i]);
               check($sformatf("mb_data%0d", i), q_data[i], exp_d[i]);
            end
         end
         check("mb_req2_granted", saw2 > 0, 1);
         check("mb_ready0_low_under_req2", bad_ready, 0);
      end

`ifdef FBUF_WR_ARB_CLIP_EN
      // Clip: first address is one past the end, second is the last pixel.
      do_reset();
      check("clip_reset", clip_err, 0);
      drive_all(3'b001, 3'b000, AW'(32'd307200), DW'(32'h11));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("clip_ready", req_ready, 3'b001);
      @(posedge clk);
      #1;
      drive_all(3'b001, 3'b001, AW'(32'd307199), DW'(32'h22));
      @(negedge clk);
      check("clip_no_write", fbuf_en_wr, 0);
      check("clip_flag_set", clip_err, 1);
      @(posedge clk);
      #1;
      drive_all(3'b000, 3'b000, '0, '0);
      @(negedge clk);
      check("clip_in_range_en", fbuf_en_wr, 1);
      check("clip_in_range_addr", fbuf_addr, 307199);
      check("clip_in_range_data", fbuf_data, 'h22);
      check("clip_sticky", clip_err, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fbuf_wr_arbiter.md
Name: fbuf_wr_arbiter

Overview:
- Shares the single write-only framebuffer BRAM port (en/wrea/addr/data) between NUM_REQ pixel-writing requesters, for example the AXI4-Lite GPU command path, a fill engine and a blitter.
- Uses round-robin arbitration with burst locking: a granted requester owns the port until it sends its last beat, or until the MAX_BURST beat limit ends the grant.
- Output is registered and sits directly in front of the framebuffer BRAM write port.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- FBUF_ADDR_WIDTH, 19, framebuffer address width.
- FBUF_DATA_WIDTH, 8, pixel width.
- MAX_BURST, 64, maximum beats per grant (power of 2, at least 2).
- FBUF_DEPTH, 307200, number of valid pixel addresses (640x480). Used only when the optional feature is compiled in.

Ports:
- fbuf_aclk  in  1  clock.
- fbuf_areset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  one bit per requester: a beat is offered.
- req_ready  out  NUM_REQ  one bit per requester: the beat is accepted.
- req_last  in  NUM_REQ  marks the final beat of a burst.
- req_addr  in  NUM_REQ*FBUF_ADDR_WIDTH  packed; requester i occupies bits [i*W +: W].
- req_data  in  NUM_REQ*FBUF_DATA_WIDTH  packed in the same way.
- fbuf_en_wr  out  1  BRAM enable.
- fbuf_wrea  out  1  BRAM write enable.
- fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM address.
- fbuf_data  out  FBUF_DATA_WIDTH  BRAM write data.
- grant_id  out  $clog2(NUM_REQ)  current owner; valid only while busy=1.
- busy  out  1  high while in the GRANT state.
- clip_err  out  1  sticky flag. This port exists only when FBUF_WR_ARB_CLIP_EN is defined.

Behaviour:
- Reset: this block has one clock, fbuf_aclk, and one reset, fbuf_areset, which is asynchronous and active-high. On reset:
  - State becomes IDLE, the round-robin pointer becomes 0 and the beat counter becomes 0.
  - All registered outputs are 0: fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data, grant_id, busy and clip_err.
  - req_ready is combinational but gated by the state, so it is also 0 during reset.
- Reset mid-burst aborts the burst. Only beats already registered have been written, and no further beats are written.
- IDLE state:
  - req_ready is all zeros.
  - If any req_valid bit is set, choose the first set index scanning upward from the pointer, wrapping modulo NUM_REQ.
  - Register that index into grant_id, clear the beat counter and move to GRANT on the next edge.
  - If no req_valid bit is set, stay in IDLE.
- GRANT state:
  - req_ready[grant_id] = 1; all other ready bits are 0.
  - A beat is accepted when req_valid[g] and req_ready[g] are both high.
  - An accepted beat is registered onto the fbuf outputs on the next edge, with fbuf_en_wr = fbuf_wrea = 1. This is a latency of 1 cycle.
  - On cycles with no accepted beat, fbuf_en_wr and fbuf_wrea go to 0 and fbuf_addr/fbuf_data hold their previous values.
  - Each accepted beat increments the beat counter.
- Leaving GRANT: leave on an accepted beat with req_last = 1, or on the accepted beat that brings the counter to MAX_BURST, whichever comes first.
  - That beat is still written.
  - The next state is IDLE and the pointer becomes (g+1) mod NUM_REQ.
  - A requester cut off by MAX_BURST must re-arbitrate; its burst continues under a later grant.
- Bubbles: there is always exactly one IDLE cycle between grants, so at most 1 bubble per grant. Throughput within a burst is 1 beat per cycle.
- Valid dropping mid-burst: if the granted requester drops req_valid mid-burst, the grant is held and no timeout is applied.
- Fairness: no requester waits more than (NUM_REQ-1) grants.

Optional Feature:
- Macro: FBUF_WR_ARB_CLIP_EN.
- When defined:
  - An accepted beat with req_addr >= FBUF_DEPTH is still acked (ready stays high) and still counts toward MAX_BURST and req_last.
  - The beat is not written: fbuf_en_wr and fbuf_wrea stay 0 for that slot.
  - clip_err is set and stays set until reset.
- When not defined:
  - The clip_err port is absent and the comparator is not built.
  - All accepted beats are written unchanged, with the address truncated to FBUF_ADDR_WIDTH.

Decomposition:
- A shared package fbuf_pkg holds:
  - the default widths (FBUF_ADDR_WIDTH, FBUF_DATA_WIDTH);
  - FBUF_DEPTH plus the screen width and height constants;
  - the state encoding typedef (ARB_IDLE, ARB_GRANT).
- One natural sub-module, rr_pick: a combinational round-robin priority selector.
  - Inputs: request vector and pointer.
  - Outputs: index and found flag.
  - It is reusable by other arbiters in the GPU.

Test Plan:
- Single requester: req1 sends 4 beats to addresses 0x10..0x13, data 0xA0..0xA3, last on beat 4. Required: grant_id=1; 4 consecutive fbuf writes, each 1 cycle after acceptance; busy drops; pointer=2.
- Round-robin: all 3 requesters offer 1-beat bursts (last=1) continuously from reset. Required: grants in order 0,1,2,0,1,2, with one IDLE cycle between grants.
- MAX_BURST cut: with MAX_BURST=4, req0 sends 6 beats with last only on the 6th while req2 is waiting. Required:
  - 4 writes from req0, then a req2 burst, then the remaining 2 beats of req0;
  - req_ready[0] is low while req2 holds the grant.
- Stall: the granted requester drops valid for 3 cycles mid-burst. Required: no writes during those cycles, en_wr=0, grant held, and the burst resumes at the correct address.
- Reset mid-burst: assert fbuf_areset asynchronously after beat 2 of 5. Required: all outputs go to 0 immediately; after release the block is in IDLE with pointer=0.
- Clip (with FBUF_WR_ARB_CLIP_EN): write to address 307200 then 307199. Required: first beat acked with no write and clip_err=1; second beat written with en_wr=1.
